// File: rtl/key_debounce.sv
// key_debounce
//   Conditions a raw, asynchronous key/switch level for the master-slave
//   flip-flop chain. The key is synchronised with two flops. A stability
//   counter then filters contact bounce. The block produces a clean
//   registered level plus one-cycle press/release pulses.
//
// Parameters
//   STABLE_CNT : consecutive synchronised samples at the new level that are
//                needed before D changes (>= 1)
//   CNT_WIDTH  : counter width, 2**CNT_WIDTH > STABLE_CNT-1
//
// Ports
//   clk           in  : system clock, rising edge
//   rst           in  : synchronous active-high reset
//   key_in        in  : raw asynchronous key level (1 = pressed)
//   D             out : debounced registered level
//   press_pulse   out : one-cycle pulse on D 0->1
//   release_pulse out : one-cycle pulse on D 1->0
//   state_o       out : FSM state (00 LOW, 01 CHK_HIGH, 10 HIGH, 11 CHK_LOW)
module key_debounce #(
  parameter int STABLE_CNT = 1000000,
  parameter int CNT_WIDTH  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       D,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_LOW      = 2'b00,
    S_CHK_HIGH = 2'b01,
    S_HIGH     = 2'b10,
    S_CHK_LOW  = 2'b11
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CNT - 1);

  logic                 sync1_q, sync2_q;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 d_q, d_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    d_d       = d_q;
    // pulses default low so they self-clear one edge after being set
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync2_q) begin
          state_d = S_CHK_HIGH;
          cnt_d   = '0;
        end
      end
      S_CHK_HIGH: begin
        if (!sync2_q) begin
          // bounce: back to the stable level, next excursion counts from 0
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          d_d     = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_HIGH: begin
        if (!sync2_q) begin
          state_d = S_CHK_LOW;
          cnt_d   = '0;
        end
      end
      S_CHK_LOW: begin
        if (sync2_q) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = S_LOW;
          cnt_d     = '0;
          d_d       = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        d_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= S_LOW;
      cnt_q     <= '0;
      d_q       <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign D             = d_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Drives two builds of key_debounce (STABLE_CNT=4 and STABLE_CNT=1) from
//   the same key/reset stimulus. Both builds are compared every cycle
//   against a run-length reference model. On top of that, directed
//   constant checks cover the latency and pulse counts of the listed
//   scenarios.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       d4, pp4, rp4, d1, pp1, rp1;
  logic [1:0] st4, st1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_debounce #(.STABLE_CNT(4), .CNT_WIDTH(3)) dut4 (
    .clk(clk), .rst(rst), .key_in(key_in), .D(d4),
    .press_pulse(pp4), .release_pulse(rp4), .state_o(st4));

  key_debounce #(.STABLE_CNT(1), .CNT_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .key_in(key_in), .D(d1),
    .press_pulse(pp1), .release_pulse(rp1), .state_o(st1));

  // Reference model. D flips once sync2 has disagreed with it on
  // STABLE_CNT+1 consecutive edges: one edge to enter the check state, then
  // STABLE_CNT counted samples.
  int   mn[2] = '{4, 1};
  logic ms1[2], ms2[2], md[2], mpp[2], mrp[2];
  int   mrun[2];
  int   npress[2], nrel[2], nhigh[2];

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] mstate(input int k);
    if (mrun[k] == 0) return md[k] ? 2'd2 : 2'd0;
    return md[k] ? 2'd3 : 2'd1;
  endfunction

  task automatic tick();
    logic       od[2], opp[2], orp[2];
    logic [1:0] ost[2];
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ms1[k] = 1'b0; ms2[k] = 1'b0; md[k] = 1'b0;
        mpp[k] = 1'b0; mrp[k] = 1'b0; mrun[k] = 0;
      end else begin
        mpp[k] = 1'b0; mrp[k] = 1'b0;
        if (ms2[k] != md[k]) begin
          mrun[k]++;
          if (mrun[k] == mn[k] + 1) begin
            md[k]   = ms2[k];
            mpp[k]  = ms2[k];
            mrp[k]  = !ms2[k];
            mrun[k] = 0;
          end
        end else begin
          mrun[k] = 0;
        end
        ms2[k] = ms1[k];
        ms1[k] = key_in;
      end
    end
    #1;
    od  = '{d4, d1};   opp = '{pp4, pp1};
    orp = '{rp4, rp1}; ost = '{st4, st1};
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_D[%0d]", k), {1'b0, od[k]}, {1'b0, md[k]});
      chk($sformatf("model_press[%0d]", k), {1'b0, opp[k]}, {1'b0, mpp[k]});
      chk($sformatf("model_release[%0d]", k), {1'b0, orp[k]}, {1'b0, mrp[k]});
      chk($sformatf("model_state[%0d]", k), ost[k], mstate(k));
      if (opp[k]) npress[k]++;
      if (orp[k]) nrel[k]++;
      if (od[k])  nhigh[k]++;
    end
  endtask

  task automatic clr_counts();
    npress = '{0, 0}; nrel = '{0, 0}; nhigh = '{0, 0};
  endtask

  task automatic hold(input logic v, input int n);
    key_in = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic pat[7] = '{1, 1, 0, 1, 1, 0, 1};
    // Reset: 2 cycles with key held high
    rst = 1'b1; key_in = 1'b1;
    tick(); tick();
    chk("reset_D", {1'b0, d4}, 2'd0);
    chk("reset_pulses", {pp4, rp4}, 2'd0);
    chk("reset_state", st4, 2'd0);
    rst = 1'b0;
    hold(1'b0, 8);

    // Clean press, edge i = i-th edge sampling key_in=1
    key_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) chk("press_chk_state", st4, 2'd1);
      if (i == 5) chk("press_not_early", {1'b0, d4}, 2'd0);
      if (i == 6) chk("press_D_pulse", {d4, pp4}, 2'b11);
      if (i == 7) chk("press_pulse_clear", {1'b0, pp4}, 2'd0);
      if (i == 7) chk("press_state_high", st4, 2'd2);
    end

    // Clean release
    key_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) chk("rel_chk_state", st4, 2'd3);
      if (i == 5) chk("rel_not_early", {1'b0, d4}, 2'd1);
      if (i == 6) chk("rel_D_pulse", {d4, rp4}, 2'b01);
      if (i == 7) chk("rel_pulse_clear", {1'b0, rp4}, 2'd0);
    end

    // 2-cycle low glitch while HIGH: no release
    hold(1'b1, 10);
    clr_counts();
    hold(1'b0, 2);
    hold(1'b1, 10);
    chk("glitch_no_release", 2'(nrel[0]), 2'd0);
    chk("glitch_stay_high", {1'b0, d4}, 2'd1);

    // Bouncy press from LOW
    hold(1'b0, 10);
    clr_counts();
    for (int i = 0; i < 17; i++) begin
      key_in = (i < 7) ? pat[i] : 1'b1;
      tick();
      if (i == 11) chk("bounce_not_early", {1'b0, d4}, 2'd0);
      if (i == 12) chk("bounce_D_rise", {d4, pp4}, 2'b11);
    end
    chk("bounce_one_press", 2'(npress[0]), 2'd1);

    // Reset mid-HIGH with key still pressed
    clr_counts();
    rst = 1'b1;
    tick();
    chk("midrst_D", {1'b0, d4}, 2'd0);
    chk("midrst_state", st4, 2'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 5) chk("midrst_not_early", {1'b0, d4}, 2'd0);
      if (i == 6) chk("midrst_press", {d4, pp4}, 2'b11);
    end
    chk("midrst_no_release", 2'(nrel[0]), 2'd0);

    // STABLE_CNT=1 build: 1-cycle pulse rejected
    hold(1'b0, 10);
    clr_counts();
    hold(1'b1, 1);
    hold(1'b0, 8);
    chk("sc1_short_no_D", 2'(nhigh[1]), 2'd0);

    // STABLE_CNT=1 build: 3-cycle pulse
    for (int i = 0; i < 12; i++) begin
      key_in = (i < 3);
      tick();
      if (i == 2) chk("sc1_not_early", {1'b0, d1}, 2'd0);
      if (i == 3) chk("sc1_rise", {d1, pp1}, 2'b11);
      if (i == 5) chk("sc1_still_high", {1'b0, d1}, 2'd1);
      if (i == 6) chk("sc1_fall", {d1, rp1}, 2'b01);
    end

    // Random runs with occasional reset
    for (int r = 0; r < 80; r++) begin
      rst = ($urandom_range(0, 19) == 0);
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Input-conditioning stage that feeds the D input of the master-slave flip-flop chain from a raw, asynchronous board key or switch. It synchronises the raw level into the `clk` domain and filters contact bounce with a stability counter. It then presents a clean registered level on `D`, plus one-cycle press and release pulses for downstream counters. It is the stage directly upstream of the flip-flop under test on the lab board.

## Interface
- `STABLE_CNT`, default 1000000: consecutive synchronised samples at the new level required before `D` changes (10 ms at 100 MHz). Legal range is 1 or more.
- `CNT_WIDTH`, default 20: counter width. Must satisfy 2^CNT_WIDTH > STABLE_CNT-1.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `key_in` in 1: raw asynchronous key level (1 = pressed).
- `D` out 1: debounced, registered key level; drives the flip-flop D input.
- `press_pulse` out 1: high for exactly one cycle when `D` goes 0→1.
- `release_pulse` out 1: high for exactly one cycle when `D` goes 1→0.
- `state_o` out 2: current FSM state, for debug (same role as `mid_Q`). Encoding: 00 LOW, 01 CHK_HIGH, 10 HIGH, 11 CHK_LOW.

## Operation
- Synchroniser: two flops, `sync1 <= key_in` and `sync2 <= sync1`. The FSM looks only at `sync2`.
- Counter `cnt` is CNT_WIDTH bits and cleared on every state entry.
- LOW (D=0):
  - `sync2`=1 → CHK_HIGH, `cnt`<=0.
  - Otherwise stay.
- CHK_HIGH (D=0):
  - `sync2`=0 → LOW (bounce rejected, no pulse).
  - `sync2`=1 and `cnt`==STABLE_CNT-1 → HIGH, `D`<=1, `press_pulse`<=1.
  - `sync2`=1 otherwise → `cnt`<=`cnt`+1.
- HIGH (D=1):
  - `sync2`=0 → CHK_LOW, `cnt`<=0.
- CHK_LOW (D=1): mirror of CHK_HIGH.
  - `sync2`=1 → HIGH.
  - `cnt`==STABLE_CNT-1 with `sync2`=0 → LOW, `D`<=0, `release_pulse`<=1.
- Pulses are registered and self-clear on the next edge. `press_pulse` and `release_pulse` are never both 1.
- `cnt` never wraps: it saturates at STABLE_CNT-1 by construction, because the state always leaves at that value.
- STABLE_CNT=1: a CHK state is held for exactly one cycle, then transitions.

## Timing
- Reset values (one edge with `rst`=1): `sync1`=0, `sync2`=0, `cnt`=0, state LOW, `D`=0, `press_pulse`=0, `release_pulse`=0, `state_o`=00.
- `rst` has priority over all other inputs on the same edge.
- Press latency: `key_in` is first sampled high at edge 0 and held. Then:
  - `sync2`=1 after edge 1.
  - CHK_HIGH after edge 2.
  - `D`=1 and `press_pulse`=1 after edge STABLE_CNT+2.
  - `press_pulse` returns to 0 after edge STABLE_CNT+3.
- Release latency is identical, measured from the first edge sampling `key_in`=0.
- Bounce rule: any `sync2` sample at the old level during a CHK state returns to the stable state on that edge. Counting restarts from 0 on the next excursion.
- Reset mid-operation (in any state, including HIGH): `D` is 0 after the reset edge and no `release_pulse` is produced.
  - If `key_in` is still high, the full press path repeats, producing `press_pulse` at edge STABLE_CNT+2 after reset release.
- Synchroniser MTBF is outside the scope of this block. `key_in` metastability is tolerated only through the two-flop chain.

## Test plan
All scenarios use STABLE_CNT=4 and CNT_WIDTH=3.
- **Reset:** hold `rst`=1 for 2 cycles with `key_in`=1 → `D`=0, pulses 0, `state_o`=00 while in reset.
- **Clean press:** `key_in` 0→1 sampled at edge 0 and held → `state_o`=01 after edge 2; `D`=1 and `press_pulse`=1 after edge 6 only; `press_pulse`=0 after edge 7; `state_o`=10.
- **Bouncy press:** `key_in` pattern 1,1,0,1,1,0,1 (one value per cycle), then held 1 → no `D` change during the pattern. `D` rises exactly 6 edges after the final 0→1 sample, with exactly one `press_pulse` total.
- **Clean release:** from HIGH, `key_in`=0 from edge 0 → `state_o`=11 after edge 2; `D`=0 and `release_pulse`=1 after edge 6. A 2-cycle low glitch instead returns to HIGH with no pulse.
- **Reset mid-HIGH:** assert `rst` one cycle while `D`=1 and `key_in`=1 → `D`=0 with no `release_pulse`. A fresh `press_pulse` occurs 6 edges after `rst` deasserts.
- **STABLE_CNT=1 build:** a single-cycle-wide `key_in` pulse produces no `D` change. A 3-cycle-wide pulse yields `D`=1 at edge 3 and `D`=0 three edges after the fall is sampled.
